noc_input_port: RTL and testbench

- Router input stage: buffers incoming flits in a circular FIFO and decodes the output port from each head flit.
- Drives a one-hot request vector into the per-output round-robin programmable priority encoders.
- Pops one flit per cycle while its request is granted.
- Wormhole switching: once a head flit is routed, the request for that output is held until the tail flit has been granted.

---
 rtl/noc_input_port.sv | 124 ++++++++++++
 tb/tb_noc_input_port.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_input_port.sv
// Router input port: circular flit FIFO with head-flit route decode and
// wormhole request holding toward the per-output arbiters.
module noc_input_port #(
   parameter int N      = 5,
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ce,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_head,
   input  logic              i_tail,
   output logic              o_ready,
   output logic [0:N-1]      o_request,
   input  logic [0:N-1]      i_grant,
   output logic [DATA_W-1:0] o_data,
   output logic              o_head,
   output logic              o_tail,
   output logic              o_error
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

   state_t            state;
   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [DEPTH-1:0]  mem_head;
   logic [DEPTH-1:0]  mem_tail;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [PW-1:0]     route;
   logic [PW-1:0]     head_port;
   logic              empty;
   logic              full;
   logic              push;
   logic              pop;
   logic              port_ok;

   assign empty     = (count == '0);
   assign full      = (count == CW'(DEPTH));
   assign o_ready   = ce & ~full;
   assign push      = i_valid & o_ready;

   assign o_data    = mem_data[rd_ptr];
   assign o_head    = mem_head[rd_ptr];
   assign o_tail    = mem_tail[rd_ptr];
   assign head_port = o_data[PW-1:0];
   assign port_ok   = (int'(head_port) < N);

   // Request is a function of registered state only, so the arbiter sees no path from i_grant.
   always_comb begin
      o_request = '0;
      if (state == ACTIVE && !empty)
         o_request[route] = 1'b1;
   end

   always_comb begin
      pop = 1'b0;
      if (ce && !empty) begin
         case (state)
            IDLE:    pop = ~(o_head & port_ok);
            ACTIVE:  pop = i_grant[route];
            DROP:    pop = 1'b1;
            default: pop = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= i_data;
         mem_head[wr_ptr] <= i_head;
         mem_tail[wr_ptr] <= i_tail;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         route   <= '0;
         o_error <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
      end else if (ce) begin
         o_error <= 1'b0;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;

         case (state)
            IDLE: begin
               if (!empty) begin
                  if (o_head && port_ok) begin
                     route <= head_port;
                     state <= ACTIVE;
                  end else begin
                     o_error <= 1'b1;
                     if (o_head && !o_tail)
                        state <= DROP;
                  end
               end
            end
            ACTIVE, DROP: begin
               if (pop && o_tail)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_noc_input_port.sv
// Bench for noc_input_port: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based packet model.
module tb_noc_input_port;

   localparam int N      = 5;
   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;
   localparam int PW     = 3;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              ce;
   logic              i_valid;
   logic [DATA_W-1:0] i_data;
   logic              i_head;
   logic              i_tail;
   logic              o_ready;
   logic [0:N-1]      o_request;
   logic [0:N-1]      i_grant;
   logic [DATA_W-1:0] o_data;
   logic              o_head;
   logic              o_tail;
   logic              o_error;

   always #5 clk = ~clk;

   noc_input_port #(.N(N), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ce        (ce),
      .i_valid   (i_valid),
      .i_data    (i_data),
      .i_head    (i_head),
      .i_tail    (i_tail),
      .o_ready   (o_ready),
      .o_request (o_request),
      .i_grant   (i_grant),
      .o_data    (o_data),
      .o_head    (o_head),
      .o_tail    (o_tail),
      .o_error   (o_error)
   );

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              head;
      logic              tail;
   } flit_t;

   typedef enum {M_IDLE, M_ACTIVE, M_DROP} mstate_t;

   flit_t   q[$];
   mstate_t ms     = M_IDLE;
   int      mroute = 0;
   logic    merr   = 1'b0;
   int      tests  = 0;
   int      fails  = 0;

   function automatic logic [0:N-1] gbit(input int p);
      logic [0:N-1] g;
      g    = '0;
      g[p] = 1'b1;
      return g;
   endfunction

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs;
      logic [0:N-1] er;
      er = '0;
      if (ms == M_ACTIVE && q.size() > 0)
         er[mroute] = 1'b1;
      chk("ready", 32'(o_ready), 32'(ce && (q.size() < DEPTH)));
      chk("request", 32'(o_request), 32'(er));
      chk("error", 32'(o_error), 32'(merr));
      if (q.size() > 0) begin
         chk("data", o_data, q[0].data);
         chk("head", 32'(o_head), 32'(q[0].head));
         chk("tail", 32'(o_tail), 32'(q[0].tail));
      end
   endtask

   task automatic model_edge;
      flit_t f;
      bit    acc;
      int    port;
      if (!reset_n) begin
         q.delete();
         ms     = M_IDLE;
         mroute = 0;
         merr   = 1'b0;
         return;
      end
      if (!ce)
         return;
      acc  = i_valid && (q.size() < DEPTH);
      merr = 1'b0;
      if (q.size() > 0) begin
         f    = q[0];
         port = int'(f.data[PW-1:0]);
         case (ms)
            M_IDLE: begin
               if (f.head && port < N) begin
                  mroute = port;
                  ms     = M_ACTIVE;
               end else begin
                  q.delete(0);
                  merr = 1'b1;
                  if (f.head && !f.tail)
                     ms = M_DROP;
               end
            end
            M_ACTIVE: begin
               if (i_grant[mroute]) begin
                  q.delete(0);
                  if (f.tail)
                     ms = M_IDLE;
               end
            end
            M_DROP: begin
               q.delete(0);
               if (f.tail)
                  ms = M_IDLE;
            end
            default: ms = M_IDLE;
         endcase
      end
      if (acc)
         q.push_back('{i_data, i_head, i_tail});
   endtask

   task automatic tick;
      @(negedge clk);
      check_outputs();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit h, input bit t);
      i_valid = v;
      i_data  = d;
      i_head  = h;
      i_tail  = t;
   endtask

   function automatic logic [DATA_W-1:0] payload(input int port);
      return ($urandom() & 32'hFFFF_FFF8) | DATA_W'(port);
   endfunction

   initial begin
      bit pend;
      bit in_pkt;
      bit acc;
      int r;

      reset_n = 1'b0;
      ce      = 1'b1;
      i_grant = '0;
      drive(0, '0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      model_edge();
      reset_n = 1'b1;
      chk("reset_ready", 32'(o_ready), 32'd1);
      chk("reset_request", 32'(o_request), 32'd0);
      chk("reset_error", 32'(o_error), 32'd0);

      // single-flit packet to port 3
      drive(1, 32'h0000_0003, 1, 1);
      tick();
      drive(0, '0, 0, 0);
      tick();
      chk("single_req_t2", 32'(o_request), 32'(5'b00010));
      i_grant = gbit(3);
      tick();
      i_grant = '0;
      chk("single_req_after", 32'(o_request), 32'd0);
      chk("single_ready_after", 32'(o_ready), 32'd1);

      // four-flit packet to port 1, grant held throughout
      i_grant = gbit(1);
      for (int i = 0; i < 4; i++) begin
         drive(1, payload(1), i == 0, i == 3);
         tick();
      end
      drive(0, '0, 0, 0);
      repeat (4) tick();
      chk("stream_req_done", 32'(o_request), 32'd0);
      i_grant = '0;

      // fill to DEPTH with no grant, stall the fifth flit
      for (int i = 0; i < 4; i++) begin
         drive(1, payload(2), i == 0, 0);
         tick();
      end
      chk("full_ready", 32'(o_ready), 32'd0);
      drive(1, payload(2), 0, 1);
      repeat (2) tick();
      i_grant = gbit(0);
      tick();
      chk("wrong_grant_ready", 32'(o_ready), 32'd0);
      i_grant = gbit(2);
      tick();
      chk("ready_after_pop", 32'(o_ready), 32'd1);
      tick();
      chk("push_pop_ready", 32'(o_ready), 32'd1);
      drive(0, '0, 0, 0);
      repeat (5) tick();
      i_grant = '0;

      // bad port: whole packet dropped, then a valid packet routes
      drive(1, payload(6), 1, 0);
      tick();
      drive(1, payload(0), 0, 0);
      tick();
      drive(1, payload(1), 0, 0);
      tick();
      drive(1, payload(2), 0, 1);
      tick();
      drive(0, '0, 0, 0);
      repeat (3) tick();
      i_grant = gbit(4);
      drive(1, payload(4), 1, 1);
      tick();
      drive(0, '0, 0, 0);
      repeat (3) tick();
      i_grant = '0;

      // stray body flit in IDLE
      drive(1, payload(1), 0, 0);
      tick();
      drive(0, '0, 0, 0);
      repeat (3) tick();

      // mid-packet clock-enable hold, then reset
      for (int i = 0; i < 3; i++) begin
         drive(1, payload(2), i == 0, 0);
         tick();
      end
      drive(0, '0, 0, 0);
      tick();
      i_grant = gbit(2);
      tick();
      ce = 1'b0;
      repeat (3) tick();
      chk("ce_hold_req", 32'(o_request), 32'(5'b00100));
      ce      = 1'b1;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      i_grant = '0;
      chk("midreset_ready", 32'(o_ready), 32'd1);
      chk("midreset_req", 32'(o_request), 32'd0);
      tick();

      // random traffic
      pend   = 0;
      in_pkt = 0;
      for (int c = 0; c < 1500; c++) begin
         ce      = ($urandom_range(0, 9) != 0);
         reset_n = ($urandom_range(0, 299) != 0);
         if (!pend && $urandom_range(0, 2) != 0) begin
            if ($urandom_range(0, 19) == 0) begin
               drive(1, payload($urandom_range(0, 7)), 0, $urandom_range(0, 1));
            end else if (!in_pkt) begin
               r = $urandom_range(0, 2);
               drive(1, payload($urandom_range(0, 7)), 1, r == 0);
               in_pkt = (r != 0);
            end else begin
               r = $urandom_range(0, 3);
               drive(1, payload($urandom_range(0, 7)), 0, r == 0);
               in_pkt = (r != 0);
            end
            pend = 1;
         end
         i_valid = pend;
         r = $urandom_range(0, 3);
         case (r)
            0:       i_grant = '0;
            1:       i_grant = gbit($urandom_range(0, N - 1));
            2:       i_grant = gbit(mroute);
            default: i_grant = '1;
         endcase
         acc = pend && ce && reset_n && (q.size() < DEPTH);
         tick();
         if (acc)
            pend = 0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
